// File: rtl/warp_scheduler_pkg.sv
// Shared types and constants for the warp scheduler slice: warp context
// layout, warp status encoding, scheduler state encoding and the default
// greedy run-length cap.
package warp_scheduler_pkg;

  localparam int WARPS_PER_CORE = 8;
  localparam int WARP_ID_WIDTH  = 3;
  localparam int DATA_WIDTH     = 32;
  localparam int WARP_SIZE      = 32;
  localparam int AGE_WIDTH      = 8;
  localparam int GTO_MAX_GREEDY = 16;

  typedef enum logic [1:0] {
    WARP_IDLE  = 2'd0,
    WARP_READY = 2'd1,
    WARP_WAIT  = 2'd2,
    WARP_DONE  = 2'd3
  } warp_status_t;

  typedef struct packed {
    logic                 valid;
    warp_status_t         status;
    logic [AGE_WIDTH-1:0] age;
    logic [DATA_WIDTH-1:0] pc;
    logic [WARP_SIZE-1:0] active_mask;
  } warp_context_t;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/warp_scheduler_if.sv
// Issue slot between the warp scheduler and fetch/decode.
//   issue_valid   : slot holds a warp (scheduler -> fetch)
//   issue_ready   : fetch accepts the slot (fetch -> scheduler)
//   issue_warp_id : warp in the slot
//   issue_pc      : PC captured when the warp was selected
//   issue_mask    : active mask captured when the warp was selected
interface warp_scheduler_if;
  import warp_scheduler_pkg::*;

  logic                     issue_valid;
  logic                     issue_ready;
  logic [WARP_ID_WIDTH-1:0] issue_warp_id;
  logic [DATA_WIDTH-1:0]    issue_pc;
  logic [WARP_SIZE-1:0]     issue_mask;

  modport master (
    output issue_valid,
    input  issue_ready,
    output issue_warp_id,
    output issue_pc,
    output issue_mask
  );

  modport slave (
    input  issue_valid,
    output issue_ready,
    input  issue_warp_id,
    input  issue_pc,
    input  issue_mask
  );
endinterface

// File: rtl/warp_scheduler_oldest_select.sv
// Combinational argmax over warp age restricted to an eligibility mask.
// Ties resolve to the lowest warp id.
//   elig_i  : per-warp eligibility
//   age_i   : per-warp age
//   found_o : at least one warp eligible
//   id_o    : oldest eligible warp (0 when none)
module warp_oldest_select
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = WARPS_PER_CORE
) (
  input  logic [NUM_WARPS-1:0]     elig_i,
  input  logic [AGE_WIDTH-1:0]     age_i [NUM_WARPS],
  output logic                     found_o,
  output logic [WARP_ID_WIDTH-1:0] id_o
);

  logic                     found;
  logic [WARP_ID_WIDTH-1:0] best_id;
  logic [AGE_WIDTH-1:0]     best_age;

  // Strict '>' keeps the first (lowest-id) warp on equal ages.
  always_comb begin
    found    = 1'b0;
    best_id  = '0;
    best_age = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (elig_i[i] && (!found || (age_i[i] > best_age))) begin
        found    = 1'b1;
        best_id  = WARP_ID_WIDTH'(i);
        best_age = age_i[i];
      end
    end
  end

  assign found_o = found;
  assign id_o    = best_id;

endmodule

// File: rtl/warp_scheduler.sv
// Greedy-then-oldest issue scheduler for one SIMT core.
// Picks one eligible warp per cycle into a registered valid/ready issue slot,
// strobes the context age logic on every accepted issue, tracks in-flight
// warps until their PC writeback retires, and flags kernel completion.
//   clk, rst            : core clock, synchronous active-high reset
//   start_i             : begin scheduling from IDLE or DONE
//   contexts_i          : live per-warp context array
//   stall_mask_i        : per-warp scoreboard/barrier block
//   retire_valid_i/id_i : PC writeback complete for a warp
//   issue_if            : issue slot (master side)
//   warp_issued_o/id_o  : registered handshake strobe to the age logic
//   busy_o, done_o      : state is RUN / DONE
//
// state      | meaning
// SCHED_IDLE | waiting for start after reset
// SCHED_RUN  | selecting and issuing warps
// SCHED_DONE | all valid warps finished, nothing in flight; waits for start
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS  = WARPS_PER_CORE,
  parameter int MAX_GREEDY = GTO_MAX_GREEDY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  warp_context_t            contexts_i [NUM_WARPS],
  input  logic [NUM_WARPS-1:0]     stall_mask_i,
  input  logic                     retire_valid_i,
  input  logic [WARP_ID_WIDTH-1:0] retire_warp_id_i,
  warp_scheduler_if.master         issue_if,
  output logic                     warp_issued_o,
  output logic [WARP_ID_WIDTH-1:0] issued_warp_id_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int ID_SPAN = 1 << WARP_ID_WIDTH;

  sched_state_t state_q, state_d;

  logic [NUM_WARPS-1:0]     inflight_q, inflight_d;
  logic [WARP_ID_WIDTH-1:0] greedy_id_q, greedy_id_d;
  logic [7:0]               greedy_cnt_q, greedy_cnt_d;

  logic                     valid_q, valid_d;
  logic [WARP_ID_WIDTH-1:0] id_q, id_d;
  logic [DATA_WIDTH-1:0]    pc_q, pc_d;
  logic [WARP_SIZE-1:0]     mask_q, mask_d;
  logic                     warp_issued_q;
  logic [WARP_ID_WIDTH-1:0] issued_id_q;

  logic [NUM_WARPS-1:0]     elig, cand;
  logic [ID_SPAN-1:0]       elig_pad;
  logic [AGE_WIDTH-1:0]     ages [NUM_WARPS];
  logic                     any_elig, greedy_elig, cap_hit, greedy_ok;
  logic                     old_found;
  logic [WARP_ID_WIDTH-1:0] old_id, sel_id;
  logic [DATA_WIDTH-1:0]    sel_pc;
  logic [WARP_SIZE-1:0]     sel_mask;
  logic                     handshake, load, start_clear, work_left;

  always_comb begin
    elig      = '0;
    work_left = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      elig[i] = contexts_i[i].valid && (contexts_i[i].status == WARP_READY) &&
                (|contexts_i[i].active_mask) && !stall_mask_i[i] && !inflight_q[i];
      ages[i] = contexts_i[i].age;
      if (contexts_i[i].valid && (contexts_i[i].status != WARP_DONE)) work_left = 1'b1;
    end
  end

  // Padded copy so greedy_id can index any encodable id safely.
  always_comb begin
    elig_pad                = '0;
    elig_pad[NUM_WARPS-1:0] = elig;
  end

  assign any_elig    = |elig;
  assign greedy_elig = elig_pad[greedy_id_q];
  assign cap_hit     = (greedy_cnt_q >= 8'(MAX_GREEDY));
  assign greedy_ok   = (greedy_cnt_q != 8'd0) && greedy_elig && !cap_hit;

  // A capped greedy warp steps aside for the oldest of the others.
  always_comb begin
    cand = elig;
    if (cap_hit && greedy_elig) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (greedy_id_q == WARP_ID_WIDTH'(i)) cand[i] = 1'b0;
      end
    end
  end

  warp_oldest_select #(
    .NUM_WARPS (NUM_WARPS)
  ) u_oldest (
    .elig_i  (cand),
    .age_i   (ages),
    .found_o (old_found),
    .id_o    (old_id)
  );

  // If nothing but the capped greedy warp is eligible, it is kept.
  assign sel_id = greedy_ok ? greedy_id_q : (old_found ? old_id : greedy_id_q);

  always_comb begin
    sel_pc   = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (sel_id == WARP_ID_WIDTH'(i)) begin
        sel_pc   = contexts_i[i].pc;
        sel_mask = contexts_i[i].active_mask;
      end
    end
  end

  assign handshake   = valid_q && issue_if.issue_ready;
  assign load        = (state_q == SCHED_RUN) && any_elig && (!valid_q || issue_if.issue_ready);
  assign start_clear = start_i && (state_q != SCHED_RUN);

  always_comb begin
    valid_d      = valid_q;
    id_d         = id_q;
    pc_d         = pc_q;
    mask_d       = mask_q;
    inflight_d   = inflight_q;
    greedy_id_d  = greedy_id_q;
    greedy_cnt_d = greedy_cnt_q;

    if (retire_valid_i) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (retire_warp_id_i == WARP_ID_WIDTH'(i)) inflight_d[i] = 1'b0;
      end
    end

    // Set is applied after clear so it wins on a same-id collision.
    if (load) begin
      valid_d = 1'b1;
      id_d    = sel_id;
      pc_d    = sel_pc;
      mask_d  = sel_mask;
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (sel_id == WARP_ID_WIDTH'(i)) inflight_d[i] = 1'b1;
      end
      if (sel_id == greedy_id_q) begin
        if (greedy_cnt_q != 8'hFF) greedy_cnt_d = greedy_cnt_q + 8'd1;
      end else begin
        greedy_id_d  = sel_id;
        greedy_cnt_d = 8'd1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (start_clear) begin
      inflight_d   = '0;
      greedy_cnt_d = 8'd0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCHED_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_IDLE: if (start_i) state_d = SCHED_RUN;
      SCHED_RUN:  if (!work_left && (inflight_q == '0) && !valid_q) state_d = SCHED_DONE;
      SCHED_DONE: if (start_i) state_d = SCHED_RUN;
      default:    state_d = SCHED_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == SCHED_RUN);
    done_o = (state_q == SCHED_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      id_q          <= '0;
      pc_q          <= '0;
      mask_q        <= '0;
      inflight_q    <= '0;
      greedy_id_q   <= '0;
      greedy_cnt_q  <= 8'd0;
      warp_issued_q <= 1'b0;
      issued_id_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      id_q          <= id_d;
      pc_q          <= pc_d;
      mask_q        <= mask_d;
      inflight_q    <= inflight_d;
      greedy_id_q   <= greedy_id_d;
      greedy_cnt_q  <= greedy_cnt_d;
      warp_issued_q <= handshake;
      if (handshake) issued_id_q <= id_q;
    end
  end

  assign issue_if.issue_valid   = valid_q;
  assign issue_if.issue_warp_id = id_q;
  assign issue_if.issue_pc      = pc_q;
  assign issue_if.issue_mask    = mask_q;
  assign warp_issued_o          = warp_issued_q;
  assign issued_warp_id_o       = issued_id_q;

endmodule
